// File: rtl/serial_divider.sv
// Multi-cycle DIV/IDIV unit: restoring division on operand magnitudes, signs fixed up at the end.
// Optional macro DIVIDER_NEG_MAX_QUOTIENT_EN accepts a signed quotient of exactly -2^(n-1).
module serial_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        complete,
  output logic        error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ABORT, S_WORK, S_FIXUP, S_DONE, S_ERR
  } state_t;

  state_t state, nxt;

  logic        is8_r, sgn_r, qneg_r, rneg_r;
  logic [31:0] dvd_r;
  logic [15:0] dvs_r, rem_r, quot_r;
  logic [4:0]  cnt_r;

  // Magnitudes and range check, evaluated while in PREP
  logic        dvd_neg, dvs_neg, prep_err;
  logic [15:0] dvd16_mag, dvs_mag, hi_mag, lo_quot;
  logic [31:0] dvd32_mag;
  logic [7:0]  dvs8_mag;
  logic [15:0] dvs16_mag;

  always_comb begin
    dvd_neg   = sgn_r & (is8_r ? dvd_r[15] : dvd_r[31]);
    dvs_neg   = sgn_r & (is8_r ? dvs_r[7]  : dvs_r[15]);
    dvd16_mag = dvd_neg ? -dvd_r[15:0] : dvd_r[15:0];
    dvd32_mag = dvd_neg ? -dvd_r       : dvd_r;
    dvs8_mag  = dvs_neg ? -dvs_r[7:0]  : dvs_r[7:0];
    dvs16_mag = dvs_neg ? -dvs_r       : dvs_r;
    dvs_mag   = is8_r ? {8'h00, dvs8_mag} : dvs16_mag;
    hi_mag    = is8_r ? {8'h00, dvd16_mag[15:8]} : dvd32_mag[31:16];
    // 8-bit low half sits in the top of quot so it shifts out cleanly and
    // leaves quot[15:8] zero after eight steps.
    lo_quot   = is8_r ? {dvd16_mag[7:0], 8'h00} : dvd32_mag[15:0];
    prep_err  = (dvs_mag == 16'h0000) || (hi_mag >= dvs_mag);
  end

  // One restoring step: 18-bit difference so the borrow is unambiguous
  logic [17:0] trial;
  logic        ge;
  always_comb begin
    trial = {1'b0, rem_r, quot_r[15]} - {2'b00, dvs_r};
    ge    = ~trial[17];
  end

  // Final sign handling and signed range check
  logic [15:0] limit, mask, q_res, r_res;
  logic        ovf;
  always_comb begin
    limit = is8_r ? 16'h0080 : 16'h8000;
    mask  = is8_r ? 16'h00FF : 16'hFFFF;
`ifdef DIVIDER_NEG_MAX_QUOTIENT_EN
    ovf   = sgn_r & ((quot_r > limit) | ((quot_r == limit) & ~qneg_r));
`else
    ovf   = sgn_r & (quot_r >= limit);
`endif
    q_res = (qneg_r ? -quot_r : quot_r) & mask;
    r_res = (rneg_r ? -rem_r  : rem_r)  & mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_PREP;
      S_PREP:  nxt = prep_err ? S_ABORT : S_WORK;
      S_ABORT: nxt = S_ERR;
      S_WORK:  if (cnt_r == 5'd1) nxt = S_FIXUP;
      S_FIXUP: nxt = ovf ? S_ERR : S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is8_r  <= 1'b0;
      sgn_r  <= 1'b0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      dvd_r  <= '0;
      dvs_r  <= '0;
      rem_r  <= '0;
      quot_r <= '0;
      cnt_r  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          is8_r <= is_8_bit;
          sgn_r <= is_signed;
          dvd_r <= dividend;
          dvs_r <= divisor;
        end
        S_PREP: begin
          rem_r  <= hi_mag;
          quot_r <= lo_quot;
          dvs_r  <= dvs_mag;
          cnt_r  <= is8_r ? 5'd8 : 5'd16;
          qneg_r <= dvd_neg ^ dvs_neg;
          rneg_r <= dvd_neg;
        end
        S_WORK: begin
          rem_r  <= ge ? trial[15:0] : {rem_r[14:0], quot_r[15]};
          quot_r <= {quot_r[14:0], ge};
          cnt_r  <= cnt_r - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs driven from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      complete  <= 1'b0;
      error     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      busy     <= nxt inside {S_ABORT, S_WORK, S_FIXUP, S_DONE, S_ERR};
      complete <= nxt inside {S_DONE, S_ERR};
      error    <= (nxt == S_ERR);
      if (state == S_FIXUP && !ovf) begin
        quotient  <= q_res;
        remainder <= r_res;
      end
    end
  end

endmodule

// File: doc/serial_divider.md
# serial_divider

Multi-cycle signed/unsigned divider for DIV/IDIV in the execute stage, alongside the ALU. Shares the ALU's operand sourcing: DX:AX or AX comes in as the dividend and the r/m operand as the divisor. Produces quotient and remainder for register writeback. Raises a single divide-error flag that the microcode sequencer turns into INT 0.

## Interface
- Parameters: none; operand widths are fixed by the 8086 architecture.
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; operands sampled on the same edge
- is_8_bit  in  1  1: AX / r/m8; 0: DX:AX / r/m16
- is_signed  in  1  1: IDIV semantics; 0: DIV
- dividend  in  32  {DX,AX}; only [15:0] used when is_8_bit
- divisor  in  16  only [7:0] used when is_8_bit
- busy  out  1  high from the edge after start until complete
- complete  out  1  one-cycle pulse; results or error valid
- error  out  1  valid with complete; divide-by-zero or quotient overflow
- quotient  out  16  8-bit results zero-extended in [15:8]
- remainder  out  16  8-bit results zero-extended in [15:8]

## Operation
- n = 8 when is_8_bit, otherwise 16. All operands and mode bits are latched on the start edge.
- **IDLE.** start moves the block to PREP. start while busy is ignored.
- **PREP.** Take magnitudes of dividend (2n bits) and divisor (n bits); signs are taken only when is_signed. Record qneg = sign(dividend) ^ sign(divisor) and rneg = sign(dividend).
  - Divisor magnitude = 0: go to ERR.
  - High half of |dividend| >= |divisor|: the quotient cannot fit in n bits; go to ERR.
  - Otherwise go to WORK with counter = n.
- **WORK.** One restoring-division step per cycle: shift {rem, quot} left by 1, trial-subtract |divisor| from rem, commit the result if non-negative, and set the quotient LSB accordingly. Decrement the counter. Go to FIXUP when it reaches 0.
- **FIXUP.** Signed overflow when |q| > 2^(n-1)-1, with the exception given under Configuration. On overflow go to ERR.
  - Otherwise: quotient = qneg ? -q : q, remainder = rneg ? -r : r, both truncated to n bits and zero-extended to 16.
  - Then go to DONE.
- **DONE.** complete=1, error=0, quotient/remainder updated; return to IDLE.
- **ERR.** complete=1, error=1; quotient/remainder hold their previous values; return to IDLE.
- The remainder always takes the dividend's sign, and the quotient truncates toward zero.
- Reset, including mid-operation: state returns to IDLE immediately; busy, complete, error, quotient and remainder all go to 0.

## Timing
- Edge E0 samples start. Each state lasts one cycle.
- Normal completion: complete is high in the cycle after edge E(n+2). That is 10 cycles for 8-bit and 18 cycles for 16-bit.
- Error from PREP: complete and error are high after edge E2.
- busy is high from after E1 until the cycle complete rises, inclusive of that cycle. It is low in the IDLE cycle that follows.
- A new start is accepted in the cycle after complete; there is no back-to-back start on the complete cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIVIDER_NEG_MAX_QUOTIENT_EN defined: a signed quotient of exactly -2^(n-1) (0x80 or 0x8000) is legal, matching 80186 behaviour. |q| = 2^(n-1) is accepted only when qneg=1.
- Undefined: 8086 behaviour. Any |q| >= 2^(n-1) in signed mode raises error.
- Unsigned operation is unaffected by the macro.

## Test plan
- 8-bit unsigned, dividend 0x0064, divisor 0x07 -> quotient 0x000E, remainder 0x0002, error 0; complete 10 cycles after start.
- 16-bit signed, dividend 0xFFFFFF9C (-100), divisor 0x0007 -> quotient 0xFFF2, remainder 0xFFFE; complete at cycle 18.
- 16-bit unsigned, divisor 0x0000 -> error=1 with complete at cycle 2; quotient/remainder unchanged from the prior operation.
- 8-bit unsigned, dividend 0x1000, divisor 0x10 (quotient 0x100) -> error=1 at cycle 2.
- 8-bit signed, dividend 0xFF80 (-128), divisor 0x01:
  - without the macro -> error=1 at cycle 10;
  - with DIVIDER_NEG_MAX_QUOTIENT_EN -> quotient 0x0080, remainder 0x0000, error 0.
- Start a 16-bit divide, assert reset_n=0 at cycle 5 -> all outputs 0 immediately. A subsequent start completes normally in 18 cycles. A start pulsed while busy is ignored, and the result matches the first operands.
